// File: rtl/asm_pkg.sv
// Shared definitions for the instruction assembler: opcodes, request
// formats and the packed result returned by the immediate packer.
package asm_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Encoding matches the 2-bit req_fmt field.
  typedef enum logic [1:0] {
    FMT_I   = 2'b00,
    FMT_S   = 2'b01,
    FMT_B   = 2'b10,
    FMT_RSV = 2'b11
  } fmt_e;

  // Output stage occupancy.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } ostate_e;

  // True when every bit of v is identical (value fits a sign-extended field).
  function automatic logic all_same(input logic [52:0] v, input logic [52:0] mask);
    return ((v & mask) == mask) || ((v & mask) == '0);
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational packer: scatters a 64-bit byte immediate into the I, S or B
// instruction fields and flags immediates that do not fit.
// Range checking is present only when INSTR_ASM_RANGE_CHECK_EN is defined;
// otherwise immediates are silently truncated and only the reserved format
// raises range_err.
module imm_pack
  import asm_pkg::*;
(
  input  fmt_e        fmt,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [63:0] imm,
  output logic [31:0] instr,
  output logic        range_err
);

  logic is_ok;  // I/S: imm[63:11] is a pure sign extension
  logic bs_ok;  // B:   imm[63:12] is a pure sign extension and imm[0] is 0

`ifdef INSTR_ASM_RANGE_CHECK_EN
  assign is_ok = all_same(imm[63:11], {53{1'b1}});
  assign bs_ok = all_same({1'b0, imm[63:12]}, {1'b0, {52{1'b1}}}) && !imm[0];
`else
  logic unused_imm;
  assign unused_imm = ^imm[63:13];
  assign is_ok      = 1'b1;
  assign bs_ok      = 1'b1;
`endif

  // Select the field layout for the requested format.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    instr     = 32'h0;
    range_err = 1'b0;
    case (fmt)
      FMT_I: begin
        instr     = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
        range_err = !is_ok;
      end
      FMT_S: begin
        instr     = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
        range_err = !is_ok;
      end
      FMT_B: begin
        instr     = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
        range_err = !bs_ok;
      end
      FMT_RSV: begin
        instr     = 32'h0;
        range_err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_assembler.sv
// Instruction assembler: encodes load/store/branch requests into 32-bit words
// tagged with a sequential word address, through a one-entry registered
// output stage with valid/ready on both sides.
// Optional feature macro: INSTR_ASM_RANGE_CHECK_EN (immediate range checks).
module instr_assembler
  import asm_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_fmt,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [2:0]        req_funct3,
  input  logic [63:0]       req_imm,
  input  logic              start_load,
  input  logic [ADDR_W-1:0] start_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic              err_sticky,
  output logic [15:0]       instr_count
);

  ostate_e           state_q, state_d;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       pk_instr;
  logic              pk_err;
  logic              accept;
  logic              handshake;

  imm_pack u_pack (
    .fmt       (fmt_e'(req_fmt)),
    .rd        (req_rd),
    .rs1       (req_rs1),
    .rs2       (req_rs2),
    .funct3    (req_funct3),
    .imm       (req_imm),
    .instr     (pk_instr),
    .range_err (pk_err)
  );

  // The stage can take a new word when empty or when its word leaves this cycle.
  assign out_valid = (state_q == ST_FULL);
  assign req_ready = !out_valid || out_ready;
  assign accept    = req_valid && req_ready;
  assign handshake = out_valid && out_ready;

  // A start_load in the accept cycle redirects that very word.
  assign cur_addr  = start_load ? start_addr : addr_cnt;

  // Output stage occupancy register.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // Next occupancy: fill on accept, drain on handshake unless refilled.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (handshake && !accept) state_d = ST_EMPTY;
    endcase
  end

  // Capture the encoded word; it holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_instr <= 32'h0;
      out_addr  <= '0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_instr <= pk_instr;
      out_addr  <= cur_addr;
      out_err   <= pk_err;
    end
  end

  // Word address counter; wraps naturally at 2^ADDR_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          addr_cnt <= '0;
    else if (accept)     addr_cnt <= cur_addr + 1'b1;
    else if (start_load) addr_cnt <= start_addr;
  end

  // Beat counter and sticky error track words actually delivered downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count <= 16'h0;
      err_sticky  <= 1'b0;
    end else if (handshake) begin
      instr_count <= instr_count + 16'h1;
      err_sticky  <= err_sticky | out_err;
    end
  end

endmodule

// File: tb/tb_instr_assembler.sv
// Self-checking bench for instr_assembler: directed requests push expected
// words into a scoreboard queue; a monitor pops and compares on each output
// handshake.
module tb_instr_assembler;

`ifdef INSTR_ASM_RANGE_CHECK_EN
  localparam logic RC = 1'b1;
`else
  localparam logic RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [1:0]  req_fmt;
  logic [4:0]  req_rd, req_rs1, req_rs2;
  logic [2:0]  req_funct3;
  logic [63:0] req_imm;
  logic        start_load;
  logic [9:0]  start_addr;
  logic        out_valid, out_ready;
  logic [31:0] out_instr;
  logic [9:0]  out_addr;
  logic        out_err, err_sticky;
  logic [15:0] instr_count;

  typedef struct {
    logic [31:0] instr;
    logic [9:0]  addr;
    logic        err;
  } exp_t;

  exp_t       exp_q[$];
  logic [9:0] exp_addr = '0;
  int         n_tests  = 0;
  int         n_fail   = 0;

  instr_assembler #(.ADDR_W(10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_fmt     (req_fmt),
    .req_rd      (req_rd),
    .req_rs1     (req_rs1),
    .req_rs2     (req_rs2),
    .req_funct3  (req_funct3),
    .req_imm     (req_imm),
    .start_load  (start_load),
    .start_addr  (start_addr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_addr    (out_addr),
    .out_err     (out_err),
    .err_sticky  (err_sticky),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present a request and wait (bounded) for acceptance; req_valid stays high.
  task automatic send(input logic [1:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [63:0] imm,
                      input logic [31:0] ei, input logic ee,
                      input logic ld, input logic [9:0] la);
    exp_t e;
    int   n;
    req_valid  = 1'b1;
    req_fmt    = fmt;
    req_rd     = rd;
    req_rs1    = rs1;
    req_rs2    = rs2;
    req_funct3 = f3;
    req_imm    = imm;
    start_load = ld;
    start_addr = la;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("req_ready_wait", req_ready, 1);
    if (req_ready) begin
      e.instr  = ei;
      e.addr   = ld ? la : exp_addr;
      e.err    = ee;
      exp_addr = e.addr + 10'd1;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    start_load = 1'b0;
  endtask

  task automatic idle();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compare every delivered word against the queue head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", out_valid, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_instr", out_instr, e.instr);
        check("out_addr",  out_addr,  e.addr);
        check("out_err",   out_err,   e.err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_fmt = '0; req_rd = '0; req_rs1 = '0;
    req_rs2 = '0; req_funct3 = '0; req_imm = '0; start_load = 1'b0;
    start_addr = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid",   out_valid,   0);
    check("rst_out_instr",   out_instr,   0);
    check("rst_out_addr",    out_addr,    0);
    check("rst_out_err",     out_err,     0);
    check("rst_err_sticky",  err_sticky,  0);
    check("rst_instr_count", instr_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back load, store, branch with a free-running consumer.
    out_ready = 1'b1;
    send(2'b00, 5'd5, 5'd2, 5'd0, 3'd3, -64'sd8, 32'hFF813283, 1'b0, 1'b0, '0);
    send(2'b01, 5'd0, 5'd2, 5'd6, 3'd3, 64'd16,  32'h00613823, 1'b0, 1'b0, '0);
    send(2'b10, 5'd0, 5'd1, 5'd2, 3'd0, -64'sd4, 32'hFE208EE3, 1'b0, 1'b0, '0);
    idle();
    drain();
    check("count_after_3", instr_count, 3);
    check("sticky_clean",  err_sticky,  0);

    // Out-of-range immediates: I with 2048, B with an odd offset.
    send(2'b00, 5'd1, 5'd0, 5'd0, 3'd0, 64'd2048, 32'h80000083, RC, 1'b0, '0);
    send(2'b10, 5'd0, 5'd0, 5'd0, 3'd0, 64'd3,    32'h00000163, RC, 1'b0, '0);
    idle();
    drain();
    check("sticky_after_range", err_sticky, RC);
    check("count_after_5", instr_count, 5);

    // Backpressure: one word held, next request stalled for five cycles.
    out_ready = 1'b0;
    send(2'b01, 5'd0, 5'd2, 5'd6, 3'd3, 64'd16, 32'h00613823, 1'b0, 1'b0, '0);
    req_fmt = 2'b00; req_rd = 5'd5; req_rs1 = 5'd2; req_funct3 = 3'd3; req_imm = -64'sd8;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_req_ready", req_ready, 0);
      check("bp_valid",     out_valid, 1);
      check("bp_instr",     out_instr, 32'h00613823);
      check("bp_addr",      out_addr,  5);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(2'b00, 5'd5, 5'd2, 5'd0, 3'd3, -64'sd8, 32'hFF813283, 1'b0, 1'b0, '0);
    idle();
    @(negedge clk);
    check("no_bubble_valid", out_valid, 1);
    check("no_bubble_addr",  out_addr,  6);
    drain();

    // Counter reload coinciding with an accept, wrap, then reserved format.
    send(2'b00, 5'd5, 5'd2, 5'd0, 3'd3, -64'sd8, 32'hFF813283, 1'b0, 1'b1, 10'd1023);
    send(2'b01, 5'd0, 5'd2, 5'd6, 3'd3, 64'd16,  32'h00613823, 1'b0, 1'b0, '0);
    send(2'b11, 5'd3, 5'd3, 5'd3, 3'd7, 64'd5,   32'h00000000, 1'b1, 1'b0, '0);
    idle();
    drain();
    check("count_after_10", instr_count, 10);
    check("sticky_rsv",     err_sticky,  1);

    // Reset while a word is pending.
    out_ready = 1'b0;
    send(2'b00, 5'd5, 5'd2, 5'd0, 3'd3, -64'sd8, 32'hFF813283, 1'b0, 1'b0, '0);
    idle();
    @(negedge clk);
    check("pre_rst_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid",  out_valid,   0);
    check("arst_count",  instr_count, 0);
    check("arst_sticky", err_sticky,  0);
    check("arst_addr",   out_addr,    0);
    exp_q.delete();
    exp_addr  = '0;
    req_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ignores_req", out_valid, 0);
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(2'b01, 5'd0, 5'd2, 5'd6, 3'd3, 64'd16, 32'h00613823, 1'b0, 1'b0, '0);
    idle();
    drain();
    check("count_after_rst", instr_count, 1);

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_assembler.md
# instr_assembler

- Encodes load (I), store (S) and branch (B) requests into 32-bit RV64 instruction words.
- Packs a 64-bit immediate into the format-specific bit fields, the inverse of the CPU's immediate extender.
- Tags each word with a sequential word address for writing into instruction memory.
- Sits between a test/boot loader and instruction memory; has a one-entry registered output stage with valid/ready on both sides.

## Interface
Parameters:
- ADDR_W, 10, word-address width; the address counter wraps at 2^ADDR_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_fmt  in  2  00 load/I, 01 store/S, 10 branch/B, 11 reserved.
- req_rd, req_rs1, req_rs2  in  5 each  register indices (rd unused for S/B; rs2 unused for I).
- req_funct3  in  3  funct3 field.
- req_imm  in  64  signed byte immediate / offset.
- start_load  in  1  loads the address counter from start_addr.
- start_addr  in  ADDR_W  new counter value.
- out_valid  out  1  encoded word available.
- out_ready  in  1  consumer takes the word when out_valid && out_ready.
- out_instr  out  32  encoded instruction.
- out_addr  out  ADDR_W  word address of out_instr.
- out_err  out  1  word is invalid (range error or reserved fmt); qualified by out_valid.
- err_sticky  out  1  set on any emitted out_err; cleared only by reset.
- instr_count  out  16  beats emitted (handshakes on the output side); wraps at 0xFFFF→0.

## Operation
- Opcodes: load 7'b0000011, store 7'b0100011, branch 7'b1100011.
- I format: [31:20]=imm[11:0], [19:15]=rs1, [14:12]=funct3, [11:7]=rd.
- S format: [31:25]=imm[11:5], [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:7]=imm[4:0].
- B format: [31]=imm[12], [30:25]=imm[10:5], [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:8]=imm[4:1], [7]=imm[11].
- Range rule for I/S: req_imm[63:11] all equal.
- Range rule for B: req_imm[63:12] all equal and req_imm[0]==0.
- On a range violation the word is still packed from the truncated bits, with out_err=1.
- Reserved fmt emits out_instr=32'h0 with out_err=1.
- Address counter:
  - Each accepted request latches the counter into out_addr, then the counter increments.
  - The counter wraps at 2^ADDR_W-1→0.
- Output stage states: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY→FULL on accept.
  - FULL→EMPTY on output handshake with no new accept.
  - FULL→FULL on simultaneous handshake and accept; the new word replaces the old one.

## Timing
- req_ready = !out_valid || out_ready. This combinational path from out_ready is the only one allowed.
- Latency: a request accepted at edge N is presented at out_valid from after edge N until its handshake.
- out_instr, out_addr and out_err stay stable while out_valid && !out_ready.
- start_load and accept in the same cycle: the accepted word gets start_addr; the counter becomes start_addr+1.
- start_load while FULL: the pending out_addr is unchanged; only the counter reloads.
- Reset values: out_valid=0, out_instr=0, out_addr=0, out_err=0, err_sticky=0, instr_count=0, address counter=0.
- Requests during reset are ignored.
- Reset mid-operation drops the pending word.
- err_sticky and instr_count update on the output handshake, not on accept.

## Configuration
- INSTR_ASM_RANGE_CHECK_EN defined: I/S/B range rules apply and drive out_err.
- Not defined: the range rules are compiled out. Immediates are silently truncated, and out_err is set only for reserved fmt.

## Structure
- Shared package asm_pkg holds:
  - opcode localparams OPC_LOAD, OPC_STORE and OPC_BRANCH;
  - fmt enum fmt_e {FMT_I, FMT_S, FMT_B, FMT_RSV}.
- Sub-module imm_pack: a combinational packer from fmt, registers, funct3 and imm to {instr, range_err}.
- The top level holds the output register, the address counter, instr_count and err_sticky.

## Test plan
- Load: fmt=I, rd=5, rs1=2, funct3=3, imm=-8 → out_instr=32'hFF813283, out_err=0, out_addr=0.
- Store: fmt=S, rs2=6, rs1=2, funct3=3, imm=16 → 32'h00613823. Branch: fmt=B, rs1=1, rs2=2, funct3=0, imm=-4 → 32'hFE208EE3. Back-to-back with out_ready=1 → out_addr 0,1,2 and instr_count=3.
- Range check (macro defined): fmt=I, imm=2048 → out_err=1, out_instr[31:20]=12'h800, err_sticky=1. fmt=B, imm=3 → out_err=1. Macro undefined: imm=2048 → out_err=0.
- Backpressure: hold out_ready=0 for 5 cycles with req_valid=1 → req_ready=0, the word is stable and one word is held. Releasing out_ready emits the next word on the following cycle without a bubble.
- Address control: start_load with start_addr=1023 in the same cycle as an accept → out_addr=1023, next word out_addr=0. fmt=11 → out_instr=0, out_err=1.
- Reset while FULL → out_valid=0 immediately (asynchronous), with counter, instr_count and err_sticky all 0.
